// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator keypad scanner and floor display driver.
package elevator_pkg;

  localparam int FLOOR_W = 5;
  localparam int KEY_W   = 4;

  // Key index = row*3 + col; indices 0..8 are the digits 1..9
  localparam logic [KEY_W-1:0] KEY_STAR = 4'd9;
  localparam logic [KEY_W-1:0] KEY_ZERO = 4'd10;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;

  // Elevator select encodings
  localparam logic ELV1 = 1'b0;
  localparam logic ELV2 = 1'b1;

  // Classification of one full scan frame
  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } scan_result_e;

  // Debounce state machine
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } deb_state_e;

  // Seven-segment pattern (gfedcba, active-high) shared with the floor display driver
  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM: qualifies a single key over DEB_CNT frames for press
// and DEB_CNT empty frames for release, producing one press strobe per keystroke.
module keypad_debounce
  import elevator_pkg::*;
#(
  parameter int DEB_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_end,
  input  scan_result_e     result,
  input  logic [KEY_W-1:0] code,
  output logic             press_pulse,
  output logic [KEY_W-1:0] press_code,
  output logic             held
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CNT);

  deb_state_e       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [KEY_W-1:0] code_reg, code_next;

  // State, frame counter and latched key code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
    end
  end

  // Next-state logic, evaluated only when a scan frame completes
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    code_next   = code_reg;
    press_pulse = 1'b0;
    if (frame_end) begin
      case (state_reg)
        ST_IDLE: begin
          if (result == RES_ONE) begin
            code_next = code;
            cnt_next  = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              state_next  = ST_PRESSED;
              press_pulse = 1'b1;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (result == RES_ONE) begin
            if (code == code_reg) begin
              cnt_next = cnt_reg + CNT_ONE;
              if (cnt_next == CNT_DONE) begin
                state_next  = ST_PRESSED;
                press_pulse = 1'b1;
              end
            end else begin
              // A different single key restarts qualification on the new key
              code_next = code;
              cnt_next  = CNT_ONE;
            end
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_PRESSED: begin
          // Any key activity keeps the press alive; no auto-repeat
          if (result == RES_NONE) begin
            if (CNT_ONE == CNT_DONE) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              state_next = ST_RELEASE;
              cnt_next   = CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (result == RES_NONE) begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          end else begin
            state_next = ST_PRESSED;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // The strobe is combinational on frame_end so the top can register the event once
  assign press_code = code_next;
  assign held       = (state_reg == ST_PRESSED) || (state_reg == ST_RELEASE);

endmodule

// File: rtl/elevator_keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, row synchronisation, per-frame
// decode and registered floor-request / elevator-select events.
module elevator_keypad_scanner
  import elevator_pkg::*;
#(
  parameter int SCAN_DIV = 16384,
  parameter int DEB_CNT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         key_row,
  output logic [2:0]         key_col,
  output logic               req_valid,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_elv,
  output logic               key_held
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

  logic [3:0]         row_meta_reg, row_sync_reg;
  logic [TW-1:0]      tick_cnt_reg;
  logic [1:0]         col_reg;
  logic [1:0]         acc_hits_reg;
  logic [KEY_W-1:0]   acc_code_reg;
  logic               req_valid_reg, req_elv_reg, elv_sel_reg;
  logic [FLOOR_W-1:0] req_floor_reg;

  logic               tick, frame_end;
  logic [1:0]         col_hits, col_row, frame_hits;
  logic [2:0]         hits_sum;
  logic [KEY_W-1:0]   frame_code;
  scan_result_e       frame_result;
  logic               press_pulse, held;
  logic [KEY_W-1:0]   press_code;

  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign frame_end = tick && (col_reg == 2'd2);
  assign key_col   = 3'b001 << col_reg;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= '0;
      row_sync_reg <= '0;
    end else begin
      row_meta_reg <= key_row;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Column dwell divider and column rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
      col_reg      <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
      col_reg      <= (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  // Decode the current column's rows and merge with the partial frame
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_sync_reg[r]) begin
        col_hits = (col_hits == 2'd2) ? 2'd2 : col_hits + 2'd1;
        col_row  = 2'(r);
      end
    end
    hits_sum   = {1'b0, acc_hits_reg} + {1'b0, col_hits};
    frame_hits = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    frame_code = (col_hits == 2'd1) ? ({2'b00, col_row} * 4'd3 + {2'b00, col_reg})
                                    : acc_code_reg;
    case (frame_hits)
      2'd0:    frame_result = RES_NONE;
      2'd1:    frame_result = RES_ONE;
      default: frame_result = RES_MULTI;
    endcase
  end

  // Frame accumulator, cleared when the frame is handed to the debouncer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits_reg <= '0;
      acc_code_reg <= '0;
    end else if (frame_end) begin
      acc_hits_reg <= '0;
      acc_code_reg <= '0;
    end else if (tick) begin
      acc_hits_reg <= frame_hits;
      acc_code_reg <= frame_code;
    end
  end

  keypad_debounce #(
    .DEB_CNT(DEB_CNT)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_end  (frame_end),
    .result     (frame_result),
    .code       (frame_code),
    .press_pulse(press_pulse),
    .press_code (press_code),
    .held       (held)
  );

  // Turn a qualified keystroke into a floor request or an elevator selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_reg <= 1'b0;
      req_floor_reg <= '0;
      req_elv_reg   <= ELV1;
      elv_sel_reg   <= ELV1;
    end else begin
      req_valid_reg <= 1'b0;
      if (press_pulse) begin
        if (press_code <= 4'd8) begin
          req_valid_reg <= 1'b1;
          req_floor_reg <= FLOOR_W'(press_code) + FLOOR_W'(1);
          req_elv_reg   <= elv_sel_reg;
        end else if (press_code == KEY_STAR) begin
          elv_sel_reg <= ELV1;
        end else if (press_code == KEY_HASH) begin
          elv_sel_reg <= ELV2;
        end
      end
    end
  end

  assign req_valid = req_valid_reg;
  assign req_floor = req_floor_reg;
  assign req_elv   = req_elv_reg;
  assign key_held  = held;

endmodule
